// File: rtl/recfn_to_fp.sv
// recfn_to_fp
// Converts a recoded floating-point operand (sign, 9-bit recoded exponent,
// 001-prefixed 32-bit significand, class flags) into an IEEE-754 binary32
// word. Subnormal results are denormalised by an iterative right shifter
// that moves one bit per clock.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  operand handshake; in_ready is high only in IDLE
//   in_sign, in_exp, in_sig, in_isNAN, in_isINf, in_isZero  operand fields
//   out_valid/out_ready result handshake; out_valid is high only in DONE
//   out_fp             IEEE binary32 result
//   out_invalid        operand encoding was malformed
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid is high and
// ready is low; out_fp/out_invalid stay constant for the whole of DONE.
module recfn_to_fp #(
    parameter int                       FP_BITS     = 32,
    parameter int                       EXP_BITS    = 8,
    parameter int                       FRA_BITS    = 23,
    parameter int                       SIG_BITS    = 32,
    parameter int                       RECEXP_BITS = 9,
    parameter logic [RECEXP_BITS-1:0]   EXP_OFFSET  = 9'h101
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [RECEXP_BITS-1:0] in_exp,
    input  logic [SIG_BITS-1:0]    in_sig,
    input  logic                   in_isNAN,
    input  logic                   in_isINf,
    input  logic                   in_isZero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP_BITS-1:0]     out_fp,
    output logic                   out_invalid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CNT_BITS = $clog2(FRA_BITS + 1);

    // Smallest recoded exponent of a normal number, and of a subnormal
    // that still keeps at least one significand bit after denormalising.
    localparam logic [RECEXP_BITS-1:0] NORM_MIN = EXP_OFFSET + 1'b1;
    localparam logic [RECEXP_BITS-1:0] SUB_MIN  = NORM_MIN - RECEXP_BITS'(FRA_BITS);

    logic [1:0]            state;
    logic [FRA_BITS:0]     mant;
    logic [CNT_BITS-1:0]   cnt;
    logic                  sign_q;

    // Decode of the current operand, consumed only on an accept edge.
    logic [FRA_BITS-1:0]    fra;
    logic                   prefix_ok;
    logic [RECEXP_BITS-1:0] norm_exp;
    logic [RECEXP_BITS-1:0] sub_k;
    logic [FP_BITS-1:0]     dec_fp;
    logic                   dec_invalid;
    logic                   dec_sub;
    logic                   unused_bits;

    assign fra       = in_sig[SIG_BITS-4 -: FRA_BITS];
    assign prefix_ok = (in_sig[SIG_BITS-1 -: 3] == 3'b001);
    assign norm_exp  = in_exp - EXP_OFFSET;
    assign sub_k     = NORM_MIN - in_exp;

    // Guard bits below the fraction and the high bits of the exponent
    // arithmetic carry no information once the range checks have passed.
    assign unused_bits = ^{in_sig[SIG_BITS-FRA_BITS-4:0],
                           norm_exp[RECEXP_BITS-1:EXP_BITS],
                           sub_k[RECEXP_BITS-1:CNT_BITS]};

    // Flags win over the exponent because the special exponent codes
    // alias ordinary normal codes.
    always_comb begin
        dec_fp      = '0;
        dec_invalid = 1'b0;
        dec_sub     = 1'b0;
        if (in_isNAN) begin
            // A NaN must keep a non-zero fraction; default to quiet NaN.
            dec_fp = {in_sign, {EXP_BITS{1'b1}},
                      (fra == '0) ? {1'b1, {(FRA_BITS-1){1'b0}}} : fra};
        end else if (in_isINf) begin
            dec_fp = {in_sign, {EXP_BITS{1'b1}}, {FRA_BITS{1'b0}}};
        end else if (in_isZero) begin
            dec_fp = {in_sign, {(FP_BITS-1){1'b0}}};
        end else if (!prefix_ok || (in_exp < SUB_MIN)) begin
            dec_fp      = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(FRA_BITS-1){1'b0}}};
            dec_invalid = 1'b1;
        end else if (in_exp >= NORM_MIN) begin
            dec_fp = {in_sign, norm_exp[EXP_BITS-1:0], fra};
        end else begin
            dec_sub = 1'b1;
        end
    end

    // in_ready is gated by rst_n so nothing looks acceptable during reset.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mant        <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            out_fp      <= '0;
            out_invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        if (dec_sub) begin
                            mant  <= {1'b1, fra};
                            cnt   <= sub_k[CNT_BITS-1:0];
                            state <= SHIFT;
                        end else begin
                            out_fp      <= dec_fp;
                            out_invalid <= dec_invalid;
                            state       <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    mant <= mant >> 1;
                    cnt  <= cnt - CNT_BITS'(1);
                    // On the last step the result takes the shift that is
                    // still pending, so mant[FRA_BITS:1] is the final fraction.
                    if (cnt == CNT_BITS'(1)) begin
                        out_fp      <= {sign_q, {EXP_BITS{1'b0}}, mant[FRA_BITS:1]};
                        out_invalid <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recfn_to_fp.sv
// Testbench for recfn_to_fp: directed cases followed by random operands,
// each result checked against an arithmetic reference model.
module tb_recfn_to_fp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [8:0]  in_exp = '0;
    logic [31:0] in_sig = '0;
    logic        in_isNAN = 1'b0;
    logic        in_isINf = 1'b0;
    logic        in_isZero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_fp;
    logic        out_invalid;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries are {invalid, fp}.
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    recfn_to_fp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_isNAN   (in_isNAN),
        .in_isINf   (in_isINf),
        .in_isZero  (in_isZero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fp     (out_fp),
        .out_invalid(out_invalid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: value of the recoded operand written straight as binary32.
    // Subnormals: the hidden one plus fraction, scaled down by 2^k.
    function automatic void model(input bit s, input int e, input bit [31:0] sig,
                                  input bit nan, input bit inf, input bit zero,
                                  output bit [31:0] fp, output bit inv, output int lat);
        int f;
        int k;
        f   = int'((sig >> 6) & 32'h007F_FFFF);
        inv = 1'b0;
        lat = 1;
        if (nan) begin
            if (f == 0) f = 1 << 22;
            fp = {s, 8'hFF, 23'(f)};
        end else if (inf) begin
            fp = {s, 8'hFF, 23'h0};
        end else if (zero) begin
            fp = {s, 31'h0};
        end else if ((sig >> 29) != 32'd1 || e < 235) begin
            fp  = 32'h7FC0_0000;
            inv = 1'b1;
        end else if (e >= 258) begin
            fp = {s, 8'(e - 257), 23'(f)};
        end else begin
            k   = 258 - e;
            fp  = {s, 8'h00, 23'((f + (1 << 23)) >> k)};
            lat = k + 1;
        end
    endfunction

    // One full transaction: accept, wait for the result, hold it for
    // `hold` cycles of backpressure (with ignored in_valid pulses), release.
    task automatic do_op(input bit s, input int e, input bit [31:0] sig,
                         input bit nan, input bit inf, input bit zero, input int hold);
        bit [31:0]   efp;
        bit          einv;
        int          elat;
        logic [32:0] exp_v;
        int          lat;
        bit          seen;
        model(s, e, sig, nan, inf, zero, efp, einv, elat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = 9'(e);
        in_sig    = sig;
        in_isNAN  = nan;
        in_isINf  = inf;
        in_isZero = zero;
        exp_q.push_back({einv, efp});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("result_seen", seen, 1);
        exp_v = exp_q.pop_front();
        if (seen) begin
            check("latency", lat, elat);
            check("out_fp", out_fp, exp_v[31:0]);
            check("out_invalid", out_invalid, exp_v[32]);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            in_exp    = 9'($urandom_range(0, 511));
            in_sig    = $urandom;
            in_isZero = 1'b1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_fp", out_fp, exp_v[31:0]);
            check("hold_invalid", out_invalid, exp_v[32]);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        in_isZero = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_dropped", out_valid, 0);
        check("back_to_idle", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int          r;
        int          e;
        bit [31:0]   sig;
        bit          nan;
        bit          inf;
        bit          zero;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_fp", out_fp, 0);
        check("rst_out_invalid", out_invalid, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Directed cases
        do_op(1'b0, 9'h180, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 0);  // 1.0
        do_op(1'b0, 235,    32'h2000_0000, 1'b0, 1'b0, 1'b0, 0);  // smallest subnormal
        do_op(1'b0, 257,    32'h3FFF_FF80, 1'b0, 1'b0, 1'b0, 0);  // largest subnormal
        do_op(1'b1, 9'h180, 32'h2000_0000, 1'b1, 1'b1, 1'b0, 0);  // NaN over Inf
        do_op(1'b0, 9'h1FF, 32'h2000_0000, 1'b0, 1'b1, 1'b0, 0);  // +Inf
        do_op(1'b1, 447,    32'h2000_0000, 1'b0, 1'b0, 1'b1, 0);  // -0
        do_op(1'b0, 100,    32'h2000_0000, 1'b0, 1'b0, 1'b0, 0);  // exponent too small
        do_op(1'b0, 384,    32'h4000_0000, 1'b0, 1'b0, 1'b0, 0);  // bad prefix
        do_op(1'b1, 511,    32'h3FFF_FFFF, 1'b0, 1'b0, 1'b0, 0);  // largest normal, guard bits set
        do_op(1'b0, 9'h180, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 5);  // backpressure

        // Reset in the middle of a subnormal shift
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 9'd240;
        in_sig   = 32'h2000_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_shift_valid", out_valid, 0);
        check("mid_shift_fp_prev", out_fp, 32'h3F80_0000);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_fp", out_fp, 0);
        check("async_rst_invalid", out_invalid, 0);
        check("async_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 9'h180, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 0);

        // Random operands
        for (int n = 0; n < 150; n++) begin
            r    = int'($urandom_range(0, 19));
            nan  = (r == 0);
            inf  = (r == 1) || (r == 0 && $urandom_range(0, 1) == 1);
            zero = (r == 2) || (r <= 1 && $urandom_range(0, 1) == 1);
            sig  = {3'b001, 23'($urandom), 6'($urandom)};
            if (r == 3)
                e = int'($urandom_range(0, 234));
            else if (r < 12)
                e = int'($urandom_range(235, 257));
            else
                e = int'($urandom_range(258, 511));
            if (r == 4) sig[31:29] = 3'($urandom);
            if (r == 5) sig[28:6] = '0;
            do_op(1'($urandom), e, sig, nan, inf, zero, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
